// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_read_arbiter
// Purpose  : Shares one AXI4 read port between instruction fetch (code) and
//            load (data); single outstanding transaction, grant locked AR->R.
//            Build macro ROUND_ROBIN_EN selects round-robin arbitration in
//            place of fixed priority with a fetch starvation limit.
// Revision : 1.0
// ============================================================================
module axi_read_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              code_arvalid_i,
    output logic              code_arready_o,
    input  logic [ADDR_W-1:0] code_araddr_i,
    input  logic [2:0]        code_arprot_i,
    output logic              code_rvalid_o,
    input  logic              code_rready_i,
    output logic [DATA_W-1:0] code_rdata_o,
    output logic [1:0]        code_rresp_o,

    input  logic              data_arvalid_i,
    output logic              data_arready_o,
    input  logic [ADDR_W-1:0] data_araddr_i,
    input  logic [2:0]        data_arprot_i,
    output logic              data_rvalid_o,
    input  logic              data_rready_i,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic [1:0]        data_rresp_o,

    output logic              mem_arvalid_o,
    input  logic              mem_arready_i,
    output logic [ADDR_W-1:0] mem_araddr_o,
    output logic [2:0]        mem_arprot_o,
    input  logic              mem_rvalid_i,
    output logic              mem_rready_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic [1:0]        mem_rresp_i,
    output logic              mem_awvalid_o,
    output logic              mem_wvalid_o,
    output logic              mem_bready_o,

    output logic [1:0]        grant_o,
    output logic              busy_o,
    output logic              error_o
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADDR = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;
    localparam logic [1:0] c_OKAY = 2'b00;

    logic [1:0] state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       error_q, error_d;
    logic [1:0] w_pick;
    logic       w_in_addr;
    logic       w_in_data;
    logic       w_r_hs;

`ifdef ROUND_ROBIN_EN
    logic       last_data_q, last_data_d;
`else
    localparam logic [7:0] c_LIMIT = 8'(STARVE_LIMIT);
    logic [7:0] starve_q, starve_d;
`endif

    assign w_in_addr = (state_q == c_ADDR);
    assign w_in_data = (state_q == c_DATA);
    assign w_r_hs    = w_in_data && mem_rvalid_i && mem_rready_o;

    // One-hot winner of the current IDLE arbitration; 2'b00 when nobody asks.
    always_comb begin
        w_pick = 2'b00;
        if (code_arvalid_i && data_arvalid_i) begin
`ifdef ROUND_ROBIN_EN
            w_pick = last_data_q ? 2'b01 : 2'b10;
`else
            w_pick = (starve_q == c_LIMIT) ? 2'b01 : 2'b10;
`endif
        end else if (code_arvalid_i) begin
            w_pick = 2'b01;
        end else if (data_arvalid_i) begin
            w_pick = 2'b10;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        error_d = error_q;
`ifdef ROUND_ROBIN_EN
        last_data_d = last_data_q;
`else
        starve_d = starve_q;
`endif
        case (state_q)
            c_IDLE: begin
                if (w_pick != 2'b00) begin
                    state_d = c_ADDR;
                    grant_d = w_pick;
`ifdef ROUND_ROBIN_EN
                    last_data_d = w_pick[1];
`else
                    if (w_pick[0]) begin
                        starve_d = 8'd0;
                    end else if (code_arvalid_i && (starve_q != c_LIMIT)) begin
                        starve_d = starve_q + 8'd1;
                    end
`endif
                end
            end
            c_ADDR: begin
                if (mem_arvalid_o && mem_arready_i) begin
                    state_d = c_DATA;
                end
            end
            c_DATA: begin
                if (w_r_hs) begin
                    state_d = c_IDLE;
                    grant_d = 2'b00;
                    if (mem_rresp_i != c_OKAY) begin
                        error_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = c_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= c_IDLE;
            grant_q <= 2'b00;
            error_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last_data_q <= 1'b1;
`else
            starve_q <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            error_q <= error_d;
`ifdef ROUND_ROBIN_EN
            last_data_q <= last_data_d;
`else
            starve_q <= starve_d;
`endif
        end
    end

    // Every handshake output is gated by state, so an async reset silences them at once.
    assign mem_arvalid_o  = w_in_addr && ((grant_q[0] && code_arvalid_i) ||
                                          (grant_q[1] && data_arvalid_i));
    assign mem_araddr_o   = grant_q[1] ? data_araddr_i : code_araddr_i;
    assign mem_arprot_o   = grant_q[1] ? data_arprot_i : code_arprot_i;
    assign code_arready_o = w_in_addr && grant_q[0] && mem_arready_i;
    assign data_arready_o = w_in_addr && grant_q[1] && mem_arready_i;

    assign mem_rready_o   = w_in_data && ((grant_q[0] && code_rready_i) ||
                                          (grant_q[1] && data_rready_i));
    assign code_rvalid_o  = w_in_data && grant_q[0] && mem_rvalid_i;
    assign data_rvalid_o  = w_in_data && grant_q[1] && mem_rvalid_i;
    assign code_rdata_o   = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign code_rresp_o   = mem_rresp_i;
    assign data_rresp_o   = mem_rresp_i;

    assign mem_awvalid_o  = 1'b0;
    assign mem_wvalid_o   = 1'b0;
    assign mem_bready_o   = 1'b0;

    assign grant_o = grant_q;
    assign busy_o  = w_in_addr || w_in_data;
    assign error_o = error_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_read_arbiter
// Purpose  : Directed, scoreboard-checked bench for axi_read_arbiter with a
//            small zero-wait memory model and re-requesting requesters.
// Revision : 1.0
// ============================================================================
module tb_axi_read_arbiter;

    logic        clk;
    logic        reset;
    logic        code_arvalid_i, code_arready_o, code_rvalid_o, code_rready_i;
    logic [31:0] code_araddr_i, code_rdata_o;
    logic [2:0]  code_arprot_i;
    logic [1:0]  code_rresp_o;
    logic        data_arvalid_i, data_arready_o, data_rvalid_o, data_rready_i;
    logic [31:0] data_araddr_i, data_rdata_o;
    logic [2:0]  data_arprot_i;
    logic [1:0]  data_rresp_o;
    logic        mem_arvalid_o, mem_arready_i, mem_rvalid_i, mem_rready_o;
    logic [31:0] mem_araddr_o, mem_rdata_i;
    logic [2:0]  mem_arprot_o;
    logic [1:0]  mem_rresp_i;
    logic        mem_awvalid_o, mem_wvalid_o, mem_bready_o;
    logic [1:0]  grant_o;
    logic        busy_o, error_o;

    axi_read_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk(clk), .reset(reset),
        .code_arvalid_i(code_arvalid_i), .code_arready_o(code_arready_o),
        .code_araddr_i(code_araddr_i), .code_arprot_i(code_arprot_i),
        .code_rvalid_o(code_rvalid_o), .code_rready_i(code_rready_i),
        .code_rdata_o(code_rdata_o), .code_rresp_o(code_rresp_o),
        .data_arvalid_i(data_arvalid_i), .data_arready_o(data_arready_o),
        .data_araddr_i(data_araddr_i), .data_arprot_i(data_arprot_i),
        .data_rvalid_o(data_rvalid_o), .data_rready_i(data_rready_i),
        .data_rdata_o(data_rdata_o), .data_rresp_o(data_rresp_o),
        .mem_arvalid_o(mem_arvalid_o), .mem_arready_i(mem_arready_i),
        .mem_araddr_o(mem_araddr_o), .mem_arprot_o(mem_arprot_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rready_o(mem_rready_o),
        .mem_rdata_i(mem_rdata_i), .mem_rresp_i(mem_rresp_i),
        .mem_awvalid_o(mem_awvalid_o), .mem_wvalid_o(mem_wvalid_o),
        .mem_bready_o(mem_bready_o),
        .grant_o(grant_o), .busy_o(busy_o), .error_o(error_o)
    );

    typedef struct packed {
        logic        port;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t        sb[$];
    int          n_asrt = 0;
    int          n_fail = 0;
    int          n_rbeats = 0;
    int          ar_stall = 0;
    int          code_reqs_left = 0;
    int          data_reqs_left = 0;
    logic [1:0]  resp_cfg = 2'b00;
    logic [31:0] ar_addr_cap;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic port, input logic [31:0] addr, input logic [1:0] resp);
        exp_t e;
        e.port = port;
        e.addr = addr;
        e.data = memf(addr);
        e.resp = resp;
        sb.push_back(e);
    endtask

    // One clock: check handshakes seen before the edge, then advance the models.
    task automatic cycle();
        logic hs_mem_ar, hs_mem_r, hs_code_ar, hs_data_ar, hs_code_r, hs_data_r, arv_pre;
        logic [1:0] exp_grant;
        exp_t e;
        @(negedge clk);
        hs_mem_ar  = mem_arvalid_o && mem_arready_i;
        hs_mem_r   = mem_rvalid_i && mem_rready_o;
        hs_code_ar = code_arvalid_i && code_arready_o;
        hs_data_ar = data_arvalid_i && data_arready_o;
        hs_code_r  = code_rvalid_o && code_rready_i;
        hs_data_r  = data_rvalid_o && data_rready_i;
        arv_pre    = mem_arvalid_o;
        if (code_rvalid_o && data_rvalid_o) chk("rvalid_exclusive", 1, 0);
        if (hs_mem_ar) begin
            ar_addr_cap = mem_araddr_o;
            if (sb.size() == 0) begin
                chk("ar_unexpected", 1, 0);
            end else begin
                exp_grant = sb[0].port ? 2'b10 : 2'b01;
                chk("ar_addr", mem_araddr_o, sb[0].addr);
                chk("ar_grant", grant_o, exp_grant);
            end
        end
        if (hs_code_r || hs_data_r) begin
            n_rbeats++;
            if (sb.size() == 0) begin
                chk("r_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("r_port", hs_data_r, e.port);
                chk("r_data", hs_data_r ? data_rdata_o : code_rdata_o, e.data);
                chk("r_resp", hs_data_r ? data_rresp_o : code_rresp_o, e.resp);
            end
        end
        @(posedge clk);
        #1;
        if (hs_code_ar) begin
            if (code_reqs_left > 0) begin
                code_reqs_left--;
                code_araddr_i = code_araddr_i + 32'd4;
            end else begin
                code_arvalid_i = 1'b0;
            end
        end
        if (hs_data_ar) begin
            if (data_reqs_left > 0) begin
                data_reqs_left--;
                data_araddr_i = data_araddr_i + 32'd4;
            end else begin
                data_arvalid_i = 1'b0;
            end
        end
        if (hs_mem_r) mem_rvalid_i = 1'b0;
        if (hs_mem_ar) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = memf(ar_addr_cap);
            mem_rresp_i  = resp_cfg;
        end
        if (arv_pre && ar_stall > 0) ar_stall--;
        mem_arready_i = (ar_stall == 0);
        #1;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && sb.size() != 0; i++) cycle();
        chk("drain_done", sb.size(), 0);
    endtask

    initial begin
        int nb;
        reset = 1'b1;
        code_arvalid_i = 1'b0; code_araddr_i = '0; code_arprot_i = '0; code_rready_i = 1'b1;
        data_arvalid_i = 1'b0; data_araddr_i = '0; data_arprot_i = '0; data_rready_i = 1'b1;
        mem_arready_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_rresp_i = '0;
        #1;
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_busy", busy_o, 0);
        chk("rst_error", error_o, 0);
        chk("rst_mem_arvalid", mem_arvalid_o, 0);
        chk("rst_mem_rready", mem_rready_o, 0);
        chk("rst_tieoff", {mem_awvalid_o, mem_wvalid_o, mem_bready_o}, 3'b000);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1;

        // Fetch only
        code_araddr_i = 32'h100; code_arprot_i = 3'b100; code_arvalid_i = 1'b1;
        push(1'b0, 32'h100, 2'b00);
        #1 chk("fetch_grant_not_yet", grant_o, 2'b00);
        cycle();
        chk("fetch_grant", grant_o, 2'b01);
        chk("fetch_busy", busy_o, 1);
        chk("fetch_araddr", mem_araddr_o, 32'h100);
        chk("fetch_arprot", mem_arprot_o, 3'b100);
        chk("fetch_data_arready", data_arready_o, 0);
        cycle();
        chk("fetch_code_rvalid", code_rvalid_o, 1);
        chk("fetch_data_rvalid", data_rvalid_o, 0);
        chk("fetch_rdata", code_rdata_o, 32'hDEADBEEF);
        cycle();
        chk("fetch_idle_busy", busy_o, 0);
        chk("fetch_idle_grant", grant_o, 2'b00);
        chk("fetch_sb", sb.size(), 0);

        // Contention: data first, one IDLE bubble, then code
        code_araddr_i = 32'h200; data_araddr_i = 32'h8000_0000; data_arprot_i = 3'b001;
        code_arvalid_i = 1'b1; data_arvalid_i = 1'b1;
        push(1'b1, 32'h8000_0000, 2'b00);
        push(1'b0, 32'h200, 2'b00);
        cycle();
        chk("cont_grant_data", grant_o, 2'b10);
        chk("cont_arprot", mem_arprot_o, 3'b001);
        chk("cont_code_arready", code_arready_o, 0);
        cycle();
        cycle();
        chk("cont_bubble_grant", grant_o, 2'b00);
        chk("cont_bubble_busy", busy_o, 0);
        cycle();
        chk("cont_grant_code", grant_o, 2'b01);
        drain(10);

        // Starvation with limit 2: D, D, C (counter clears), D, C
        code_araddr_i = 32'h300; data_araddr_i = 32'h8000_1000;
        code_reqs_left = 1; data_reqs_left = 2;
        code_arvalid_i = 1'b1; data_arvalid_i = 1'b1;
        push(1'b1, 32'h8000_1000, 2'b00);
        push(1'b1, 32'h8000_1004, 2'b00);
        push(1'b0, 32'h300, 2'b00);
        push(1'b1, 32'h8000_1008, 2'b00);
        push(1'b0, 32'h304, 2'b00);
        drain(60);
        cycle();
        chk("starve_quiet", busy_o, 0);

        // Backpressure on AR then on R
        ar_stall = 5; mem_arready_i = 1'b0;
        code_araddr_i = 32'h400; code_arvalid_i = 1'b1;
        push(1'b0, 32'h400, 2'b00);
        cycle();
        for (int i = 0; i < 5; i++) begin
            chk("bp_ar_grant", grant_o, 2'b01);
            chk("bp_ar_addr", mem_araddr_o, 32'h400);
            chk("bp_ar_ready", code_arready_o, 0);
            cycle();
        end
        chk("bp_ar_release", code_arready_o, 1);
        code_rready_i = 1'b0;
        cycle();
        for (int i = 0; i < 3; i++) begin
            chk("bp_r_grant", grant_o, 2'b01);
            chk("bp_r_rvalid", code_rvalid_o, 1);
            chk("bp_r_mem_rready", mem_rready_o, 0);
            cycle();
        end
        code_rready_i = 1'b1;
        nb = n_rbeats;
        cycle();
        chk("bp_done_busy", busy_o, 0);
        repeat (3) cycle();
        chk("bp_once", n_rbeats, nb + 1);

        // SLVERR sets sticky error
        resp_cfg = 2'b10;
        data_araddr_i = 32'h9000; data_arvalid_i = 1'b1;
        push(1'b1, 32'h9000, 2'b10);
        chk("err_before", error_o, 0);
        drain(10);
        chk("err_set", error_o, 1);
        resp_cfg = 2'b00;
        code_araddr_i = 32'h500; code_arvalid_i = 1'b1;
        push(1'b0, 32'h500, 2'b00);
        drain(10);
        chk("err_sticky", error_o, 1);

        // Async reset while in DATA
        code_araddr_i = 32'h600; code_arvalid_i = 1'b1;
        push(1'b0, 32'h600, 2'b00);
        cycle();
        cycle();
        chk("ar_pre_rready", mem_rready_o, 1);
        chk("ar_pre_rvalid", code_rvalid_o, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_grant", grant_o, 2'b00);
        chk("arst_busy", busy_o, 0);
        chk("arst_rready", mem_rready_o, 0);
        chk("arst_rvalid", code_rvalid_o, 0);
        chk("arst_error", error_o, 0);
        mem_rvalid_i = 1'b0;
        sb.delete();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        code_araddr_i = 32'h700; code_arvalid_i = 1'b1;
        push(1'b0, 32'h700, 2'b00);
        cycle();
        chk("post_rst_grant", grant_o, 2'b01);
        drain(10);
        chk("post_rst_busy", busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares one AXI4 read port to memory between two requesters.
- Requester 0 is instruction fetch (code port); requester 1 is the load path of the memory stage (data port).
- Sits between the core and the memory interconnect.
- Single outstanding transaction. Grant is locked from address acceptance through data return; arbitration is fixed-priority with anti-starvation.

Parameters:
- STARVE_LIMIT, 8: consecutive arbitration losses by fetch before fetch is forced to win the next arbitration; range 1..255.

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous active-high reset
- code  axi.slave  axi interface  requester 0 (fetch); only AR and R channels are used
- data  axi.slave  axi interface  requester 1 (load); only AR and R channels are used
- mem  axi.master  axi interface  shared memory port; AW/W/B tied inactive (awvalid=0, wvalid=0, bready=0)
- grant  output  2  one-hot current owner; bit0 = code, bit1 = data; 2'b00 when idle
- busy  output  1  high in ADDR or DATA state
- error  output  1  sticky; set when any R beat completes with rresp != axi4::OKAY; cleared only by reset

Behaviour:
- Reset (async, active-high): state=IDLE, grant=0, busy=0, error=0, starve counter=0. All slave arready/rvalid=0; mem.arvalid=0, mem.rready=0. A reset mid-transaction abandons the transfer immediately; no replay.
- FSM:
  - IDLE -> ADDR: on any arvalid.
  - ADDR -> DATA: on mem.arvalid & mem.arready.
  - DATA -> IDLE: on mem.rvalid & mem.rready.
  - No other transitions.
- IDLE arbitration (registered; grant is valid the cycle after the request is seen):
  - Only data.arvalid: grant data.
  - Only code.arvalid: grant code.
  - Both:
    - starve counter == STARVE_LIMIT: grant code.
    - Otherwise: grant data, and increment the counter.
  - Counter clears whenever code is granted. It saturates at STARVE_LIMIT.
- ADDR state (combinational mux from the granted slave):
  - mem.arvalid, araddr and arprot come from the granted slave.
  - Granted slave's arready = mem.arready. Non-granted slave's arready = 0.
- DATA state:
  - mem.rready = granted slave's rready.
  - Granted slave's rvalid = mem.rvalid. rdata/rresp are broadcast to both slaves. Non-granted slave's rvalid = 0.
  - arready = 0 for both slaves.
- Grant is held from IDLE exit until R handshake completes. A requester dropping arvalid while granted is illegal per AXI and is not handled.
- Back-to-back transactions: one IDLE bubble cycle between an R handshake and the next grant. Minimum 3 cycles per transaction with zero-wait memory.
- Simultaneous R handshake and new arvalid: the request is registered in IDLE on the following cycle. It is not lost, since AXI requires arvalid to be held.
- error: set on the clock edge of any R handshake with rresp != OKAY. No effect on the FSM.

Optional Feature:
- ROUND_ROBIN_EN:
  - Defined: arbitration is round-robin. On contention, the requester not granted last wins. The last-winner flop resets to data, so code wins first contention. STARVE_LIMIT is unused and the starve counter is not built.
  - Undefined: fixed-priority with starvation limit as specified above.

Test Plan:
- Fetch only: code.arvalid at araddr=0x100, memory returns rdata=0xDEADBEEF one cycle after AR. Required: grant=01 one cycle after request, mem.araddr=0x100, code sees rvalid with 0xDEADBEEF, data.rvalid stays 0, busy returns to 0.
- Contention, fixed priority: both request (code 0x200, data 0x8000_0000). Required: data is served first; code is served next after one IDLE cycle.
- Starvation, STARVE_LIMIT=2: code held and data re-requesting continuously. Required: data wins 2 arbitrations, code wins the 3rd, counter clears, and data wins the 4th.
- Backpressure: mem.arready low for 5 cycles, then the R beat is held off by code.rready=0 for 3 cycles. Required: araddr stays stable and grant stays 01 throughout; transaction completes exactly once.
- Error: R beat with rresp=SLVERR. Required: error=1 from the next cycle, persists through later OKAY beats, and clears only on reset.
- Async reset asserted in DATA state between clock edges. Required: grant=00, busy=0, mem.rready=0, and slave rvalid=0 immediately, without waiting for a clk edge; the next request after reset is served normally.
